// File: rtl/fb_pkg.sv
// fb_pkg: framebuffer geometry, pixel word type and loader FSM states shared by the loader and the renderer
package fb_pkg;
    localparam int WIDTH          = 640;
    localparam int HEIGHT         = 480;
    localparam int DATA_WIDTH     = 24;
    localparam int MEM_DEPTH      = WIDTH * HEIGHT;
    localparam int MEM_ADDR_WIDTH = $clog2(MEM_DEPTH);
    typedef logic [23:0] pixel_t;
    typedef enum logic [1:0] {WAIT_SOF, GET_R, GET_G, GET_B} loader_state_t;
endpackage

// File: rtl/framebuffer_loader.sv
// framebuffer_loader: packs an R,G,B byte stream into one framebuffer write per pixel
//   CLK, RST_N             clock, asynchronous active-low reset
//   s_data/s_valid/s_sof   byte stream in; s_sof marks the R byte of pixel 0
//   s_ready                high on every cycle out of reset, the source is never stalled
//   wr_en/wr_addr/wr_data  registered write strobe, pixel address, packed {R,G,B}
//   frame_done             pulses with the write of the last pixel of the frame
//   sof_err                pulses when an SOF arrives mid-frame and the loader resyncs
//   busy                   a frame is in progress
//   frame_checksum         16-bit sum of the bytes of the last completed frame,
//                          present only when FB_LOADER_CHECKSUM_EN is defined
module framebuffer_loader
    import fb_pkg::*;
#(
    parameter int WIDTH = fb_pkg::WIDTH,
    parameter int HEIGHT = fb_pkg::HEIGHT,
    localparam int MEM_DEPTH = WIDTH * HEIGHT,
    localparam int MEM_ADDR_WIDTH = $clog2(MEM_DEPTH)
) (
    input  logic                      CLK,
    input  logic                      RST_N,
    input  logic [7:0]                s_data,
    input  logic                      s_valid,
    input  logic                      s_sof,
    output logic                      s_ready,
    output logic                      wr_en,
    output logic [MEM_ADDR_WIDTH-1:0] wr_addr,
    output logic [DATA_WIDTH-1:0]     wr_data,
    output logic                      frame_done,
    output logic                      sof_err,
`ifdef FB_LOADER_CHECKSUM_EN
    output logic                      busy,
    output logic [15:0]               frame_checksum
`else
    output logic                      busy
`endif
);
    loader_state_t state, state_d;
    logic [MEM_ADDR_WIDTH-1:0] cnt, cnt_d;
    logic [7:0] r_q, r_d, g_q, g_d;
    logic we_d, done_d, err_d, acc, last;
    pixel_t pix;
    assign acc  = s_valid && s_ready;
    assign last = cnt == MEM_ADDR_WIDTH'(MEM_DEPTH - 1);
    assign pix  = {r_q, g_q, s_data};
    assign busy = state != WAIT_SOF;
    // An accepted SOF always restarts at pixel 0, whatever state the frame was in.
    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        r_d     = r_q;
        g_d     = g_q;
        we_d    = 1'b0;
        done_d  = 1'b0;
        err_d   = 1'b0;
        if (acc && s_sof) begin
            state_d = GET_G;
            cnt_d   = '0;
            r_d     = s_data;
            err_d   = state != WAIT_SOF;
        end else if (acc) begin
            case (state)
                GET_R: begin
                    r_d     = s_data;
                    state_d = GET_G;
                end
                GET_G: begin
                    g_d     = s_data;
                    state_d = GET_B;
                end
                GET_B: begin
                    we_d    = 1'b1;
                    done_d  = last;
                    cnt_d   = last ? '0 : cnt + 1'b1;
                    state_d = last ? WAIT_SOF : GET_R;
                end
                default: ;
            endcase
        end
    end
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state      <= WAIT_SOF;
            cnt        <= '0;
            r_q        <= '0;
            g_q        <= '0;
            s_ready    <= 1'b0;
            wr_en      <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= '0;
            frame_done <= 1'b0;
            sof_err    <= 1'b0;
        end else begin
            state      <= state_d;
            cnt        <= cnt_d;
            r_q        <= r_d;
            g_q        <= g_d;
            s_ready    <= 1'b1;
            wr_en      <= we_d;
            frame_done <= done_d;
            sof_err    <= err_d;
            if (we_d) begin
                wr_addr <= cnt;
                wr_data <= pix;
            end
        end
    end
`ifdef FB_LOADER_CHECKSUM_EN
    // Running sum restarts on every SOF so a resync discards the aborted frame's bytes.
    logic [15:0] sum_q, sum_d;
    assign sum_d = (s_sof ? 16'd0 : sum_q) + 16'(s_data);
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            sum_q          <= '0;
            frame_checksum <= '0;
        end else if (acc && (s_sof || state != WAIT_SOF)) begin
            sum_q <= sum_d;
            if (done_d) frame_checksum <= sum_d;
        end
    end
`endif
endmodule
